// File: rtl/if_ctrl_pkg.sv
// Shared encodings for the IF-stage hazard/redirect controller.
// Also holds the load-use hazard term used by the controller.
package if_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } ctrl_state_e;

  localparam logic [1:0]  PCSEL_SEQ = 2'd0;
  localparam logic [1:0]  PCSEL_BR  = 2'd1;
  localparam logic [1:0]  PCSEL_JMP = 2'd2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // r0 is hardwired to zero, so a load targeting it can never create a hazard
  function automatic logic load_use_hazard(
    input logic       mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rs,
    input logic       uses_rt
  );
    logic hit_rs;
    logic hit_rt;
    hit_rs = uses_rs && (rs == ex_rt);
    hit_rt = uses_rt && (rt == ex_rt);
    return mem_read && (ex_rt != 5'd0) && (hit_rs || hit_rt);
  endfunction

endpackage

// File: rtl/if_stage_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // count register: hold at all-ones instead of wrapping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= {W{1'b0}};
    end else if (clr) begin
      r_count <= {W{1'b0}};
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/if_stage_controller.sv
// Front-end hazard/redirect controller: boot freeze, load-use stall,
// branch/jump redirects, fetch-hold bubbles and stall/flush perf counters.
module if_stage_controller
  import if_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             fetch_hold,
  input  logic             clr_counters,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  ctrl_state_e r_state;
  ctrl_state_e w_next_state;
  logic [3:0]  r_boot_cnt;
  logic        w_lu;
  logic        w_pc_write;
  logic [1:0]  w_pc_sel;
  logic        w_if_id_write;
  logic        w_if_id_flush;
  logic        w_id_ex_bubble;
  logic        w_stall_inc;
  logic        w_flush_inc;

  assign w_lu = load_use_hazard(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rs, id_uses_rt);

  // state and boot-counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_BOOT;
      r_boot_cnt <= 4'd0;
    end else begin
      r_state    <= w_next_state;
      r_boot_cnt <= (r_state == ST_BOOT) ? (r_boot_cnt + 4'd1) : r_boot_cnt;
    end
  end

  // next state and Mealy control outputs; defaults are the frozen/boot values
  always_comb begin
    w_next_state   = r_state;
    w_pc_write     = 1'b0;
    w_pc_sel       = PCSEL_SEQ;
    w_if_id_write  = 1'b0;
    w_if_id_flush  = 1'b1;
    w_id_ex_bubble = 1'b1;
    case (r_state)
      ST_BOOT: begin
        if (r_boot_cnt == BOOT_LAST) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_BOOT;
        end
      end
      ST_RUN, ST_STALL: begin
        w_next_state = ST_RUN;
        if (branch_taken) begin
          w_pc_sel       = PCSEL_BR;
          w_pc_write     = 1'b1;
          w_if_id_write  = 1'b1;
          w_if_id_flush  = 1'b1;
          w_id_ex_bubble = 1'b1;
        // lu is masked in STALL so a held load-use pair cannot stall twice
        end else if (w_lu && (r_state == ST_RUN)) begin
          w_next_state   = ST_STALL;
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b0;
          w_if_id_flush  = 1'b0;
          w_id_ex_bubble = 1'b1;
        end else if (jump) begin
          w_pc_sel       = PCSEL_JMP;
          w_pc_write     = 1'b1;
          w_if_id_write  = 1'b1;
          w_if_id_flush  = 1'b1;
          w_id_ex_bubble = 1'b0;
        end else if (fetch_hold) begin
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b1;
          w_if_id_flush  = 1'b1;
          w_id_ex_bubble = 1'b0;
        end else begin
          w_pc_write     = 1'b1;
          w_if_id_write  = 1'b1;
          w_if_id_flush  = 1'b0;
          w_id_ex_bubble = 1'b0;
        end
      end
      default: begin
        w_next_state = ST_BOOT;
      end
    endcase
  end

  assign w_stall_inc = (r_state != ST_BOOT) && !w_pc_write;
  assign w_flush_inc = (r_state != ST_BOOT) && (w_pc_sel != PCSEL_SEQ);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (w_stall_inc),
    .clr     (clr_counters),
    .count   (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (w_flush_inc),
    .clr     (clr_counters),
    .count   (flush_count)
  );

  assign pc_write     = w_pc_write;
  assign pc_sel       = w_pc_sel;
  assign if_id_write  = w_if_id_write;
  assign if_id_flush  = w_if_id_flush;
  assign id_ex_bubble = w_id_ex_bubble;
  assign ctrl_state   = r_state;

endmodule

// File: tb/tb_if_stage_controller.sv
// Self-checking bench for if_stage_controller: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_if_stage_controller;

  localparam int BOOT_CYCLES = 2;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rs, id_uses_rt, ex_mem_read;
  logic             branch_taken, jump, fetch_hold, clr_counters;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic [1:0]       pc_sel, ctrl_state;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_age;
  bit m_in_stall;
  int m_stall;
  int m_flush;

  // expected outputs for the current cycle
  logic       e_pc_write, e_if_id_write, e_if_id_flush, e_id_ex_bubble;
  logic [1:0] e_pc_sel, e_state;
  bit         e_lu;

  if_stage_controller #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .jump         (jump),
    .fetch_hold   (fetch_hold),
    .clr_counters (clr_counters),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ctrl_state   (ctrl_state),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  always #5 clock = ~clock;

  // Expected outputs from the controller's rules; hazard from a read-register set.
  task automatic model_eval();
    logic [31:0] reads;
    reads = 32'd0;
    if (id_uses_rs) reads[id_rs] = 1'b1;
    if (id_uses_rt) reads[id_rt] = 1'b1;
    e_lu = ex_mem_read && (ex_rt != 5'd0) && reads[ex_rt] && !m_in_stall;
    {e_pc_write, e_pc_sel, e_if_id_write, e_if_id_flush, e_id_ex_bubble, e_state} =
      {1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0};
    if (reset_n && m_age >= BOOT_CYCLES) begin
      e_state = m_in_stall ? 2'd2 : 2'd1;
      if (branch_taken)    {e_pc_write, e_pc_sel, e_if_id_write, e_if_id_flush, e_id_ex_bubble} = {1'b1, 2'd1, 1'b1, 1'b1, 1'b1};
      else if (e_lu)       {e_pc_write, e_pc_sel, e_if_id_write, e_if_id_flush, e_id_ex_bubble} = {1'b0, 2'd0, 1'b0, 1'b0, 1'b1};
      else if (jump)       {e_pc_write, e_pc_sel, e_if_id_write, e_if_id_flush, e_id_ex_bubble} = {1'b1, 2'd2, 1'b1, 1'b1, 1'b0};
      else if (fetch_hold) {e_pc_write, e_pc_sel, e_if_id_write, e_if_id_flush, e_id_ex_bubble} = {1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
      else                 {e_pc_write, e_pc_sel, e_if_id_write, e_if_id_flush, e_id_ex_bubble} = {1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
    end
  endtask

  // Advance one clock edge, updating the model alongside the DUT.
  task automatic tick();
    bit run;
    int n_age, n_stall, n_flush;
    bit n_in_stall;
    model_eval();
    run = (m_age >= BOOT_CYCLES);
    n_age = run ? m_age : m_age + 1;
    n_in_stall = run && e_lu && !branch_taken;
    n_stall = m_stall + ((run && !e_pc_write) ? 1 : 0);
    n_flush = m_flush + ((run && (branch_taken || (jump && !e_lu))) ? 1 : 0);
    if (n_stall > CNT_MAX) n_stall = CNT_MAX;
    if (n_flush > CNT_MAX) n_flush = CNT_MAX;
    if (clr_counters) begin
      n_stall = 0;
      n_flush = 0;
    end
    @(posedge clock);
    if (!reset_n) begin
      m_age = 0; m_in_stall = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_age = n_age; m_in_stall = n_in_stall; m_stall = n_stall; m_flush = n_flush;
    end
    #1;
  endtask

  task automatic set_idle();
    {id_rs, id_rt, ex_rt} = 15'd0;
    {id_uses_rs, id_uses_rt, ex_mem_read} = 3'b000;
    {branch_taken, jump, fetch_hold, clr_counters} = 4'b0000;
  endtask

  task automatic clear_counters();
    set_idle();
    clr_counters = 1'b1;
    tick();
    clr_counters = 1'b0;
  endtask

  task automatic set_hazard(input logic [4:0] rt);
    ex_mem_read = 1'b1; ex_rt = rt; id_rs = 5'd5; id_uses_rs = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_idle();
    m_age = 0; m_in_stall = 0; m_stall = 0; m_flush = 0;
    #1;
    n_vec++;
    if ({pc_write, pc_sel, if_id_write, if_id_flush, id_ex_bubble, ctrl_state} !== 8'b0_00_0_1_1_00) begin
      n_err++; $display("FAIL reset_outputs got %b want 00001100", {pc_write, pc_sel, if_id_write, if_id_flush, id_ex_bubble, ctrl_state});
    end
    tick(); tick();
    reset_n = 1'b1;
    for (int c = 1; c <= BOOT_CYCLES; c++) begin
      @(negedge clock);
      n_vec++;
      if (pc_write !== 1'b0 || if_id_flush !== 1'b1 || ctrl_state !== 2'd0) begin
        n_err++; $display("FAIL boot_cycle%0d got pcw=%b flush=%b st=%0d want 0 1 0", c, pc_write, if_id_flush, ctrl_state);
      end
      tick();
    end
    @(negedge clock);
    n_vec++;
    if (ctrl_state !== 2'd1 || pc_write !== 1'b1 || pc_sel !== 2'd0) begin
      n_err++; $display("FAIL first_run got st=%0d pcw=%b sel=%0d want 1 1 0", ctrl_state, pc_write, pc_sel);
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_counters();
    set_hazard(5'd5);
    @(negedge clock);
    n_vec++;
    if (pc_write !== 1'b0 || id_ex_bubble !== 1'b1 || if_id_write !== 1'b0) begin
      n_err++; $display("FAIL lu_stall got pcw=%b bub=%b ifw=%b want 0 1 0", pc_write, id_ex_bubble, if_id_write);
    end
    tick();
    @(negedge clock);
    n_vec++;
    if (ctrl_state !== 2'd2 || pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
      n_err++; $display("FAIL lu_release got st=%0d pcw=%b bub=%b want 2 1 0", ctrl_state, pc_write, id_ex_bubble);
    end
    tick();
    set_idle();
    @(negedge clock);
    n_vec++;
    if (stall_count !== 4'd1 || ctrl_state !== 2'd1) begin
      n_err++; $display("FAIL lu_count got stall=%0d st=%0d want 1 1", stall_count, ctrl_state);
    end
    tick();
  endtask

  task automatic test_r0_no_stall();
    clear_counters();
    set_hazard(5'd0);
    id_rs = 5'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      n_vec++;
      if (pc_write !== 1'b1 || ctrl_state !== 2'd1) begin
        n_err++; $display("FAIL r0_nostall got pcw=%b st=%0d want 1 1", pc_write, ctrl_state);
      end
      tick();
    end
    set_idle();
    @(negedge clock);
    n_vec++;
    if (stall_count !== 4'd0) begin
      n_err++; $display("FAIL r0_count got %0d want 0", stall_count);
    end
  endtask

  task automatic test_priority();
    clear_counters();
    set_hazard(5'd5);
    branch_taken = 1'b1; jump = 1'b1;
    @(negedge clock);
    n_vec++;
    if ({pc_sel, if_id_flush, id_ex_bubble, pc_write} !== 5'b01_1_1_1) begin
      n_err++; $display("FAIL branch_priority got %b want 01111", {pc_sel, if_id_flush, id_ex_bubble, pc_write});
    end
    tick();
    set_idle();
    @(negedge clock);
    n_vec++;
    if (flush_count !== 4'd1 || ctrl_state !== 2'd1) begin
      n_err++; $display("FAIL branch_count got flush=%0d st=%0d want 1 1", flush_count, ctrl_state);
    end
  endtask

  task automatic test_jump_after_stall();
    clear_counters();
    set_hazard(5'd5);
    jump = 1'b1;
    @(negedge clock);
    n_vec++;
    if (pc_write !== 1'b0 || pc_sel !== 2'd0) begin
      n_err++; $display("FAIL jmp_held got pcw=%b sel=%0d want 0 0", pc_write, pc_sel);
    end
    tick();
    @(negedge clock);
    n_vec++;
    if (pc_sel !== 2'd2 || if_id_flush !== 1'b1 || pc_write !== 1'b1) begin
      n_err++; $display("FAIL jmp_taken got sel=%0d flush=%b pcw=%b want 2 1 1", pc_sel, if_id_flush, pc_write);
    end
    tick();
    set_idle();
    @(negedge clock);
    n_vec++;
    if (flush_count !== 4'd1 || stall_count !== 4'd1) begin
      n_err++; $display("FAIL jmp_counts got flush=%0d stall=%0d want 1 1", flush_count, stall_count);
    end
  endtask

  task automatic test_fetch_hold();
    clear_counters();
    fetch_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_vec++;
      if (pc_write !== 1'b0 || if_id_flush !== 1'b1 || if_id_write !== 1'b1) begin
        n_err++; $display("FAIL hold_cycle%0d got pcw=%b flush=%b ifw=%b want 0 1 1", c, pc_write, if_id_flush, if_id_write);
      end
      tick();
    end
    set_idle();
    @(negedge clock);
    n_vec++;
    if (stall_count !== 4'd3) begin
      n_err++; $display("FAIL hold_count got %0d want 3", stall_count);
    end
  endtask

  task automatic test_saturation();
    clear_counters();
    fetch_hold = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    set_idle();
    @(negedge clock);
    n_vec++;
    if (stall_count !== 4'(CNT_MAX)) begin
      n_err++; $display("FAIL saturate got %0d want %0d", stall_count, CNT_MAX);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    set_idle();
    fetch_hold = 1'b1; tick();
    set_hazard(5'd5); fetch_hold = 1'b0;
    tick();
    n_vec++;
    if (ctrl_state !== 2'd2) begin
      n_err++; $display("FAIL pre_reset_state got %0d want 2", ctrl_state);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({pc_write, pc_sel, if_id_write, if_id_flush, id_ex_bubble, ctrl_state, stall_count, flush_count} !== 16'b0_00_0_1_1_00_0000_0000) begin
      n_err++; $display("FAIL mid_stall_reset got pcw=%b st=%0d stall=%0d flush=%0d want 0 0 0 0", pc_write, ctrl_state, stall_count, flush_count);
    end
    tick();
    reset_n = 1'b1;
    set_idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_rt        = 5'($urandom_range(0, 3));
      id_uses_rs   = 1'($urandom_range(0, 1));
      id_uses_rt   = 1'($urandom_range(0, 1));
      ex_mem_read  = ($urandom_range(0, 2) != 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      jump         = ($urandom_range(0, 4) == 0);
      fetch_hold   = ($urandom_range(0, 4) == 0);
      clr_counters = ($urandom_range(0, 19) == 0);
      @(negedge clock);
      model_eval();
      n_vec++;
      if ({pc_write, pc_sel, if_id_write, if_id_flush, id_ex_bubble, ctrl_state} !==
          {e_pc_write, e_pc_sel, e_if_id_write, e_if_id_flush, e_id_ex_bubble, e_state}) begin
        n_err++;
        $display("FAIL rand_ctrl c=%0d got %b want %b", c,
          {pc_write, pc_sel, if_id_write, if_id_flush, id_ex_bubble, ctrl_state},
          {e_pc_write, e_pc_sel, e_if_id_write, e_if_id_flush, e_id_ex_bubble, e_state});
      end
      n_vec++;
      if (stall_count !== 4'(m_stall) || flush_count !== 4'(m_flush)) begin
        n_err++; $display("FAIL rand_counters c=%0d got %0d/%0d want %0d/%0d", c, stall_count, flush_count, m_stall, m_flush);
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_r0_no_stall();
    test_priority();
    test_jump_after_stall();
    test_fetch_hold();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
